// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and constants for the ADC capture controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_capture_ctrl_pkg;

    localparam int DATA_W = 64;     // packed sample word
    localparam int IDX_W  = 56;     // sample index carried in s_user/m_user
    localparam int TAG_W  = 7;      // tag type field
    localparam int CNT_W  = 32;     // burst length / delivered word counter

    // Tag types understood by the downstream tag insert mux.
    localparam logic [TAG_W-1:0] RWT_TAG_START = 7'h01;
    localparam logic [TAG_W-1:0] RWT_TAG_STOP  = 7'h02;  // reserved, not emitted yet

    // Capture controller states; the encoding is visible on sts_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TAG   = 2'd2,
        ST_RUN   = 2'd3
    } cap_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Handshake bundle around the capture controller: upstream samples, downstream words, tag requests.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel.
// Ports: s_* upstream sample stream, m_* downstream word stream, tag_* tag request.
interface adc_capture_ctrl_if;
    import adc_capture_ctrl_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [IDX_W-1:0]  s_user;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_user;
    logic              m_last;

    logic              tag_valid;
    logic              tag_ready;
    logic [TAG_W-1:0]  tag_type;
    logic [IDX_W-1:0]  tag_data;

    // Controller view.
    modport master (
        input  s_valid, s_data, s_user, m_ready, tag_ready,
        output s_ready, m_valid, m_data, m_user, m_last, tag_valid, tag_type, tag_data
    );

    // Environment view (sample source, downstream sink, tag mux).
    modport slave (
        output s_valid, s_data, s_user, m_ready, tag_ready,
        input  s_ready, m_valid, m_data, m_user, m_last, tag_valid, tag_type, tag_data
    );

endinterface

// File: rtl/adc_capture_ctrl.sv
// Gates a continuous ADC sample stream into bounded captures, optionally preceded by a START tag.
// Latency: zero-cycle combinational pass-through of words while running; tag request registered.
// Backpressure: while running s_ready follows m_ready; outside a capture words are drained; held off during TAG.
// Ports: clk/resetn (sync, active-low); cmd_start/cmd_stop pulses; cfg_* capture setup;
//        bus (master modport) s_*/m_*/tag_* handshakes; sts_state/sts_late/sts_words status.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cfg_timed,
    input  logic [IDX_W-1:0]  cfg_start_time,
    input  logic [CNT_W-1:0]  cfg_burst_len,
    input  logic              cfg_start_tag_en,
    adc_capture_ctrl_if.master bus,
    output logic [1:0]        sts_state,
    output logic              sts_late,
    output logic [CNT_W-1:0]  sts_words
);

    cap_state_t        r_state;
    logic              r_stop_pend;
    logic              r_late;
    logic [CNT_W-1:0]  r_words;
    logic              r_tag_valid;
    logic [TAG_W-1:0]  r_tag_type;
    logic [IDX_W-1:0]  r_tag_data;

    logic w_start_hit;  // this cycle's upstream word opens the capture
    logic w_pass;       // upstream is wired straight through to downstream
    logic w_last;       // an accepted word this cycle closes the capture
    logic w_acc;        // downstream handshake

    always_comb begin
        // A stop in ARMED wins over a coincident start word.
        w_start_hit = (r_state == ST_ARMED) && !cmd_stop && bus.s_valid &&
                      (!cfg_timed || (bus.s_user >= cfg_start_time));
        // Without a tag the start word goes out in the same cycle it is found.
        w_pass      = (r_state == ST_RUN) || (w_start_hit && !cfg_start_tag_en);
        w_last      = r_stop_pend ||
                      ((cfg_burst_len != '0) && (r_words == cfg_burst_len - 32'd1));
        w_acc       = w_pass && bus.s_valid && bus.m_ready;
    end

    assign bus.m_valid = w_pass && bus.s_valid;
    assign bus.m_data  = bus.s_data;
    assign bus.m_user  = bus.s_user;
    assign bus.m_last  = bus.m_valid && w_last;
    // Outside a capture words are drained so the sample index keeps moving;
    // the start word is held back while its tag is outstanding.
    assign bus.s_ready = w_pass ? bus.m_ready : !((r_state == ST_TAG) || w_start_hit);

    assign bus.tag_valid = r_tag_valid;
    assign bus.tag_type  = r_tag_type;
    assign bus.tag_data  = r_tag_data;

    assign sts_state = r_state;
    assign sts_late  = r_late;
    assign sts_words = r_words;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_stop_pend <= 1'b0;
            r_late      <= 1'b0;
            r_words     <= '0;
            r_tag_valid <= 1'b0;
            r_tag_type  <= RWT_TAG_START;
            r_tag_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        r_state <= ST_ARMED;
                        r_words <= '0;
                        r_late  <= 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (cmd_stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_start_hit) begin
                        if (cfg_timed && (bus.s_user > cfg_start_time)) begin
                            r_late <= 1'b1;
                        end
                        if (cfg_start_tag_en) begin
                            r_state     <= ST_TAG;
                            r_tag_valid <= 1'b1;
                            r_tag_type  <= RWT_TAG_START;
                            r_tag_data  <= bus.s_user;
                        end else if (w_acc && w_last) begin
                            r_state <= ST_IDLE;     // single-word burst
                        end else begin
                            r_state <= ST_RUN;
                        end
                        if (w_acc) begin
                            r_words <= sat_inc(r_words);
                        end
                    end
                end

                ST_TAG: begin
                    if (cmd_stop) begin
                        r_state     <= ST_IDLE;
                        r_tag_valid <= 1'b0;
                    end else if (bus.tag_ready) begin
                        r_state     <= ST_RUN;
                        r_tag_valid <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (w_acc) begin
                        r_words <= sat_inc(r_words);
                    end
                    // Closing word wins over a coincident stop, so only one m_last goes out.
                    if (w_acc && w_last) begin
                        r_state     <= ST_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (cmd_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
